// File: rtl/decoder_3to8.sv
// 3-to-8 line decoder with a combinational output and a load-gated registered copy.
// The OUT_ACTIVE_LOW parameter selects one-hot (0) or one-cold (1) output polarity.
module decoder_3to8 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel,
  input  logic       load,
  output logic [7:0] Y,
  output logic [7:0] Y_q,
  output logic [2:0] sel_q,
  output logic       valid_q
);

  // Pattern with no output asserted; also the reset value of Y_q.
  localparam logic [7:0] IDLE_PATTERN = {8{OUT_ACTIVE_LOW}};

  logic [7:0] onehot;
  logic [7:0] y_d;
  logic [2:0] sel_d;
  logic       valid_d;

  // An unknown sel makes every compare unknown, so Y goes all-X in simulation.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign onehot[gi] = (sel == 3'(gi));
    end
  endgenerate

  assign Y = onehot ^ IDLE_PATTERN;

  always_comb begin
    y_d     = Y_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (load) begin
      y_d     = Y;
      sel_d   = sel;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y_q     <= IDLE_PATTERN;
      sel_q   <= 3'b000;
      valid_q <= 1'b0;
    end else begin
      Y_q     <= y_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: table-driven sweep, directed corner cases,
// and randomized load/reset traffic against an arithmetic reference model.
module tb_decoder_3to8;

  logic       clk = 1'b0;
  bit         clk_run = 1'b0;
  logic       rst;
  logic [2:0] sel;
  logic       load;

  logic [7:0] y_hi, yq_hi, y_lo, yq_lo;
  logic [2:0] selq_hi, selq_lo;
  logic       vq_hi, vq_lo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] y;
  } vec_t;
  vec_t vecs[8];

  int  exp_sel;
  bit  exp_valid;

  decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .sel(sel), .load(load),
    .Y(y_hi), .Y_q(yq_hi), .sel_q(selq_hi), .valid_q(vq_hi)
  );

  decoder_3to8 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .sel(sel), .load(load),
    .Y(y_lo), .Y_q(yq_lo), .sel_q(selq_lo), .valid_q(vq_lo)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic logic [7:0] ref_decode(int s, bit low);
    logic [7:0] v;
    v = 8'(2 ** s);
    return low ? ~v : v;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output of both instances against the model state.
  task automatic check_all(string tag);
    check({tag, " Y hi"}, y_hi, ref_decode(int'(sel), 1'b0));
    check({tag, " Y lo"}, y_lo, ref_decode(int'(sel), 1'b1));
    check({tag, " Y_q hi"}, yq_hi, exp_valid ? ref_decode(exp_sel, 1'b0) : 8'h00);
    check({tag, " Y_q lo"}, yq_lo, exp_valid ? ref_decode(exp_sel, 1'b1) : 8'hFF);
    check({tag, " sel_q hi"}, 8'(selq_hi), 8'(exp_sel));
    check({tag, " sel_q lo"}, 8'(selq_lo), 8'(exp_sel));
    check({tag, " valid_q hi"}, 8'(vq_hi), 8'(exp_valid));
    check({tag, " valid_q lo"}, 8'(vq_lo), 8'(exp_valid));
  endtask

  task automatic model_reset();
    exp_sel   = 0;
    exp_valid = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) model_reset();
    else if (load) begin
      exp_sel   = int'(sel);
      exp_valid = 1'b1;
    end
  endtask

  task automatic cycle(logic [2:0] s, logic ld, logic r, string tag);
    @(negedge clk);
    sel  = s;
    load = ld;
    rst  = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    $display("cycle %s: sel=%0d load=%0b rst=%0b -> Y_q=%b sel_q=%0d valid_q=%0b",
             tag, s, ld, r, yq_hi, selq_hi, vq_hi);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{3'd0, 8'b00000001};
    vecs[1] = '{3'd1, 8'b00000010};
    vecs[2] = '{3'd2, 8'b00000100};
    vecs[3] = '{3'd3, 8'b00001000};
    vecs[4] = '{3'd4, 8'b00010000};
    vecs[5] = '{3'd5, 8'b00100000};
    vecs[6] = '{3'd6, 8'b01000000};
    vecs[7] = '{3'd7, 8'b10000000};

    rst  = 1'b1;
    load = 1'b0;
    sel  = 3'd0;
    model_reset();
    #1;
    check_all("reset");
    $display("reset: Y_q hi=%b lo=%b", yq_hi, yq_lo);

    // Combinational sweep, clock stopped and reset held (Y must ignore reset).
    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel;
      #10;
      check("sweep Y hi", y_hi, vecs[i].y);
      check("sweep Y lo", y_lo, ~vecs[i].y);
      check("sweep onehot count", 8'($countones(y_hi)), 8'd1);
      $display("sweep: sel=%0d Y=%b Y(low)=%b", sel, y_hi, y_lo);
    end

    sel = 3'b000;
    #10;
    check("pair Y 000", y_hi, 8'b00000001);
    sel = 3'b011;
    #10;
    check("pair Y 011", y_hi, 8'b00001000);
    check("polarity Y 011", y_lo, 8'b11110111);
    check("polarity Y_q reset", yq_lo, 8'b11111111);
    $display("pair: sel=011 Y=%b Y(low)=%b", y_hi, y_lo);

    rst = 1'b0;
    clk_run = 1'b1;

    cycle(3'b101, 1'b1, 1'b0, "capture");
    check("capture Y_q 101", yq_hi, 8'b00100000);
    cycle(3'b010, 1'b0, 1'b0, "hold1");
    cycle(3'b110, 1'b0, 1'b0, "hold2");
    check("hold Y_q", yq_hi, 8'b00100000);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async rst");
    check("async rst Y_q", yq_hi, 8'h00);
    $display("async reset: Y_q=%b sel_q=%0d valid_q=%0b Y=%b", yq_hi, selq_hi, vq_hi, y_hi);

    cycle(3'b110, 1'b1, 1'b1, "rst+load");
    cycle(3'b110, 1'b1, 1'b0, "first load");
    check("first load Y_q", yq_hi, 8'b01000000);

    cycle(3'b001, 1'b1, 1'b0, "b2b0");
    cycle(3'b111, 1'b1, 1'b0, "b2b1");
    cycle(3'b000, 1'b1, 1'b0, "b2b2");
    check("b2b last Y_q", yq_hi, 8'b00000001);

    for (int n = 0; n < 300; n++) begin
      cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
